// File: rtl/pipelined_segment_adder_if.sv
// Operand and result valid/ready channels of pipelined_segment_adder.
// The master drives operands and out_ready; the slave (the adder) drives the results.
interface pipelined_segment_adder_if #(
  parameter int WIDTH = 108
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/pipelined_segment_adder.sv
// Segmented add/subtract with one registered SEG_W-bit slice per stage and carry between stages.
// Unconsumed operand slices shrink stage by stage while finished sum slices accumulate.
module pipelined_segment_adder #(
  parameter int WIDTH = 108,
  parameter int SEG_W = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pipelined_segment_adder_if.slave  bus
);
  localparam int NSEG = WIDTH / SEG_W;

  if ((WIDTH % SEG_W) != 0 || NSEG < 1) begin : g_bad_cfg
    $error("pipelined_segment_adder: WIDTH must be a nonzero multiple of SEG_W");
  end

  logic w_en;

  // The whole pipe advances together; a held output result freezes every stage.
  assign w_en         = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = w_en;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int SRC_W = WIDTH - k * SEG_W;

    logic [SRC_W-1:0]         w_a_src;
    logic [SRC_W-1:0]         w_b_src;
    logic                     w_c_in;
    logic                     w_v_in;
    logic [SEG_W:0]           w_seg;
    logic [(k+1)*SEG_W-1:0]   w_s_nxt;
    logic [(k+1)*SEG_W-1:0]   r_s;
    logic                     r_cy;
    logic                     r_vld;

    if (k == 0) begin : g_head
      // Subtraction is folded in here: B is inverted once and the carry-in forced high.
      assign w_a_src = bus.in_a;
      assign w_b_src = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign w_c_in  = bus.in_sub | bus.in_cin;
      assign w_v_in  = bus.in_valid;
      assign w_s_nxt = w_seg[SEG_W-1:0];
    end else begin : g_body
      assign w_a_src = g_stage[k-1].g_fwd.r_a;
      assign w_b_src = g_stage[k-1].g_fwd.r_b;
      assign w_c_in  = g_stage[k-1].r_cy;
      assign w_v_in  = g_stage[k-1].r_vld;
      assign w_s_nxt = {w_seg[SEG_W-1:0], g_stage[k-1].r_s};
    end

    assign w_seg = {1'b0, w_a_src[SEG_W-1:0]} + {1'b0, w_b_src[SEG_W-1:0]}
                 + {{SEG_W{1'b0}}, w_c_in};

    // Partial sum, inter-stage carry and valid bit of this stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s   <= '0;
        r_cy  <= 1'b0;
        r_vld <= 1'b0;
      end else if (w_en) begin
        r_s   <= w_s_nxt;
        r_cy  <= w_seg[SEG_W];
        r_vld <= w_v_in;
      end
    end

    if (k < NSEG - 1) begin : g_fwd
      logic [SRC_W-SEG_W-1:0] r_a;
      logic [SRC_W-SEG_W-1:0] r_b;

      // Operand slices not yet added move on with their transaction.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_src[SRC_W-1:SEG_W];
          r_b <= w_b_src[SRC_W-1:SEG_W];
        end
      end
    end
  end

  assign bus.out_valid = g_stage[NSEG-1].r_vld;
  assign bus.out_sum   = g_stage[NSEG-1].r_s;
  assign bus.out_cout  = g_stage[NSEG-1].r_cy;
endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Directed bench for pipelined_segment_adder: 108/12 main instance with a scoreboard,
// plus a 12/6 legacy-equivalent instance.
module tb_pipelined_segment_adder;
  localparam int W   = 108;
  localparam int SW  = 12;
  localparam int NS  = W / SW;
  localparam int LW  = 12;
  localparam int LSW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_segment_adder_if #(.WIDTH(W))  bus ();
  pipelined_segment_adder_if #(.WIDTH(LW)) lbus ();

  pipelined_segment_adder #(.WIDTH(W), .SEG_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  pipelined_segment_adder #(.WIDTH(LW), .SEG_W(LSW)) dut_legacy (
    .clk(clk), .rst_n(rst_n), .bus(lbus.slave)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_pop = 0;
  logic [W:0] sb_q[$];

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub | cin)};
  endfunction

  // Scoreboard: push on every accepted operand, pop and compare on every delivered result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready)
        sb_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
      if (bus.out_valid && bus.out_ready) begin
        chk_bit("sb_has_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          chk("sb_result", {bus.out_cout, bus.out_sum}, sb_q.pop_front());
          n_pop++;
        end
      end
    end
  end

  task automatic drive_rand();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    bus.in_a = r[W-1:0];
    r = {$urandom, $urandom, $urandom, $urandom};
    bus.in_b     = r[W-1:0];
    bus.in_cin   = 1'($urandom_range(0, 1));
    bus.in_sub   = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1;
  endtask

  // Single operation into an empty pipe; checks latency and the constant expected result.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic [W:0] exp);
    int lat;
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_int({tag, "_latency"}, lat, NS);
    chk({tag, "_result"}, {bus.out_cout, bus.out_sum}, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W:0] held;
    int         p0;
    int         lat;

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.in_sub = 1'b0;
    bus.out_ready = 1'b1;
    lbus.in_valid = 1'b0; lbus.in_a = '0; lbus.in_b = '0; lbus.in_cin = 1'b0; lbus.in_sub = 1'b0;
    lbus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    chk_bit("reset_in_ready", bus.in_ready, 1'b1);
    chk_bit("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out", {bus.out_cout, bus.out_sum}, {(W+1){1'b0}});
    chk_bit("reset_legacy_valid", lbus.out_valid, 1'b0);

    run_one("ripple", {W{1'b1}}, {{(W-1){1'b0}}, 1'b1}, 1'b0, 1'b0, {1'b1, {W{1'b0}}});
    run_one("sub_5_7", {{(W-3){1'b0}}, 3'd5}, {{(W-3){1'b0}}, 3'd7}, 1'b0, 1'b1,
            {1'b0, {(W-2){1'b1}}, 2'b10});
    run_one("sub_7_5", {{(W-3){1'b0}}, 3'd7}, {{(W-3){1'b0}}, 3'd5}, 1'b1, 1'b1,
            {1'b1, {(W-2){1'b0}}, 2'b10});
    run_one("add_cin", {{(W-3){1'b0}}, 3'd7}, {{(W-3){1'b0}}, 3'd5}, 1'b1, 1'b0,
            {{(W-3){1'b0}}, 4'd13});

    // Streaming at full rate.
    p0 = n_pop;
    for (int i = 1; i <= 32; i++) begin
      drive_rand();
      @(posedge clk); #1;
      if (i >= NS) chk_bit("stream_out_valid", bus.out_valid, 1'b1);
    end
    bus.in_valid = 1'b0;
    for (int j = 1; j < NS; j++) begin
      @(posedge clk); #1;
      chk_bit("stream_tail_valid", bus.out_valid, 1'b1);
    end
    @(posedge clk); #1;
    chk_bit("stream_idle", bus.out_valid, 1'b0);
    chk_int("stream_count", n_pop - p0, 32);
    chk_int("stream_sb_empty", sb_q.size(), 0);

    // Backpressure on a full pipe.
    p0 = n_pop;
    for (int i = 0; i < NS; i++) begin
      drive_rand();
      @(posedge clk); #1;
    end
    chk_bit("bp_full_valid", bus.out_valid, 1'b1);
    drive_rand();
    bus.out_ready = 1'b0;
    #1;
    chk_bit("bp_in_ready_low", bus.in_ready, 1'b0);
    held = {bus.out_cout, bus.out_sum};
    repeat (3) begin
      @(posedge clk); #1;
      chk_bit("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_result", {bus.out_cout, bus.out_sum}, held);
      chk_bit("bp_hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int t = 0; t < 40 && sb_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk_int("bp_count", n_pop - p0, NS + 1);
    chk_int("bp_sb_empty", sb_q.size(), 0);

    // Reset with five operations in flight.
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_bit("rst_mid_valid", bus.out_valid, 1'b0);
    chk("rst_mid_out", {bus.out_cout, bus.out_sum}, {(W+1){1'b0}});
    sb_q.delete();
    p0 = n_pop;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 2 * NS; t++) begin
      @(posedge clk); #1;
      chk_bit("rst_no_stale", bus.out_valid, 1'b0);
    end
    chk_int("rst_no_pop", n_pop - p0, 0);

    // Legacy 12-bit configuration.
    lbus.in_a = 12'hFC0; lbus.in_b = 12'h040; lbus.in_cin = 1'b1; lbus.in_sub = 1'b0;
    lbus.in_valid = 1'b1;
    @(posedge clk); #1;
    lbus.in_valid = 1'b0;
    lat = 1;
    while (!lbus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk_int("legacy_latency", lat, 2);
    chk("legacy_sum", {{(W-LW+1){1'b0}}, lbus.out_sum}, {{(W-LW+1){1'b0}}, 12'h001});
    chk_bit("legacy_cout", lbus.out_cout, 1'b1);
    @(posedge clk); #1;
    lbus.in_a = 12'h005; lbus.in_b = 12'h007; lbus.in_cin = 1'b0; lbus.in_sub = 1'b1;
    lbus.in_valid = 1'b1;
    @(posedge clk); #1;
    lbus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk_bit("legacy_sub_valid", lbus.out_valid, 1'b1);
    chk("legacy_sub_sum", {{(W-LW+1){1'b0}}, lbus.out_sum}, {{(W-LW+1){1'b0}}, 12'hFFE});
    chk_bit("legacy_sub_cout", lbus.out_cout, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
